param_branch_predictor: RTL and testbench

PARAM_BRANCH_PREDICTOR -- requirements
Module: param_branch_predictor

---
 rtl/param_branch_predictor.sv | 120 ++++++++++++
 tb/tb_param_branch_predictor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/param_branch_predictor.sv
// param_branch_predictor: PHT + direct-mapped BTB branch predictor with power-up init sweep.
// Define BP_GSHARE_EN to XOR global history into the PHT index; default build is bimodal.
module param_branch_predictor #(
    parameter int PC_W      = 32,
    parameter int IDX_W     = 8,
    parameter int HIST_W    = 8,
    parameter int CTR_W     = 2,
    parameter int BTB_IDX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fe_req_valid,
    input  logic [PC_W-1:0]   fe_pc,
    output logic              ready,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict
);
    localparam int TAG_W = PC_W - BTB_IDX_W - 2;
    localparam int PHT_N = 1 << IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);

    typedef enum logic {INIT, READY} state_t;
    state_t state, state_nx;

    logic [IDX_W-1:0]     ptr;
    logic [HIST_W-1:0]    ghr;
    logic [CTR_W-1:0]     pht [PHT_N];
    logic                 btb_v [BTB_N];
    logic [TAG_W-1:0]     btb_tag [BTB_N];
    logic [PC_W-1:0]      btb_tgt [BTB_N];
    logic [IDX_W-1:0]     fe_idx, upd_idx;
    logic [BTB_IDX_W-1:0] fe_bidx, upd_bidx;
    logic                 lookup, update, fe_hit, fe_taken;
    logic [CTR_W-1:0]     upd_ctr, upd_ctr_nx;

`ifdef BP_GSHARE_EN
    logic unused_ok;
    assign unused_ok = ^upd_pc[1:0];
    assign fe_idx  = fe_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign upd_idx = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
`else
    logic unused_ok;
    assign unused_ok = ^{upd_pc[1:0], upd_ghr, upd_mispredict};
    assign fe_idx  = fe_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
`endif

    assign fe_bidx  = fe_pc[BTB_IDX_W+1:2];
    assign upd_bidx = upd_pc[BTB_IDX_W+1:2];
    assign lookup   = ready && fe_req_valid;
    assign update   = ready && upd_valid;
    assign fe_hit   = btb_v[fe_bidx] && (btb_tag[fe_bidx] == fe_pc[PC_W-1:BTB_IDX_W+2]);
    assign fe_taken = fe_hit && pht[fe_idx][CTR_W-1];
    assign upd_ctr  = pht[upd_idx];
    assign upd_ctr_nx = upd_taken ? ((&upd_ctr) ? upd_ctr : upd_ctr + 1'b1)
                                  : ((|upd_ctr) ? upd_ctr - 1'b1 : upd_ctr);

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = (state == INIT && &ptr) ? READY : state;
    end

    always_comb begin
        ready = (state == READY);
    end

    // Table storage has no reset; the sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            pht[ptr] <= WEAK_NT;
            if (int'(ptr) < BTB_N) btb_v[ptr[BTB_IDX_W-1:0]] <= 1'b0;
        end else if (update) begin
            pht[upd_idx] <= upd_ctr_nx;
            if (upd_taken) begin
                btb_v[upd_bidx]   <= 1'b1;
                btb_tag[upd_bidx] <= upd_pc[PC_W-1:BTB_IDX_W+2];
                btb_tgt[upd_bidx] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            ghr         <= '0;
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_ghr    <= '0;
        end else begin
            ptr        <= (state == INIT) ? ptr + 1'b1 : ptr;
            pred_valid <= lookup;
            if (lookup) begin
                pred_taken  <= fe_taken;
                pred_target <= fe_hit ? btb_tgt[fe_bidx] : fe_pc + PC_W'(4);
                pred_ghr    <= ghr;
            end
`ifdef BP_GSHARE_EN
            // A resolved mispredict outranks this cycle's speculative history shift.
            if (update && upd_mispredict) ghr <= {upd_ghr[HIST_W-2:0], upd_taken};
            else if (lookup)              ghr <= {ghr[HIST_W-2:0], fe_taken};
`else
            ghr <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_param_branch_predictor.sv
// tb_param_branch_predictor: randomized + directed scoreboard bench for param_branch_predictor.
// Reference model tracks counters and BTB entries as plain integers and arrays.
module tb_param_branch_predictor;
    logic clk = 0, reset = 1, fe_req_valid = 0, upd_valid = 0, upd_taken = 0, upd_mispredict = 0;
    logic [31:0] fe_pc = 0, upd_pc = 0, upd_target = 0, pred_target;
    logic [7:0] upd_ghr = 0, pred_ghr;
    logic ready, pred_valid, pred_taken;
    int checks = 0, errors = 0;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [7:0]  ghr;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int          pht_m [256];
    bit          bv_m [16];
    logic [31:0] btag_m [16];
    logic [31:0] btgt_m [16];
    int          ghr_m;

    always #5 clk = ~clk;

    param_branch_predictor dut (
        .clk(clk), .reset(reset), .fe_req_valid(fe_req_valid), .fe_pc(fe_pc),
        .ready(ready), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ghr(pred_ghr), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (pred_valid === 1'b1 || exp_q.size() != 0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pred_spurious got pred_valid=%0b want 0", pred_valid);
            end else begin
                mon_e = exp_q.pop_front();
                if (pred_valid !== 1'b1 || pred_taken !== mon_e.taken ||
                    pred_target !== mon_e.target || pred_ghr !== mon_e.ghr) begin
                    errors++;
                    $display("FAIL pred got v=%0b t=%0b tgt=%0h ghr=%0h want v=1 t=%0b tgt=%0h ghr=%0h",
                             pred_valid, pred_taken, pred_target, pred_ghr,
                             mon_e.taken, mon_e.target, mon_e.ghr);
                end
            end
        end
    end

    function automatic int pidx(input logic [31:0] pc, input int g);
`ifdef BP_GSHARE_EN
        return int'(((pc >> 2) ^ 32'(g)) & 32'hFF);
`else
        return int'((pc >> 2) & 32'hFF) + 0 * g;
`endif
    endfunction

    task automatic model_init();
        for (int i = 0; i < 256; i++) pht_m[i] = 1;
        for (int i = 0; i < 16; i++) bv_m[i] = 0;
        ghr_m = 0;
    endtask

    task automatic step(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                        input logic [7:0] ughr, input bit ut, input logic [31:0] utgt, input bit um);
        exp_t e;
        int i, b;
        bit hit;
        fe_req_valid = lv; fe_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_ghr = ughr; upd_taken = ut; upd_target = utgt; upd_mispredict = um;
        e = '{1'b0, 32'h0, 8'h0};
        if (lv) begin
            i = pidx(lpc, ghr_m);
            b = int'((lpc >> 2) & 32'hF);
            hit = bv_m[b] && btag_m[b] == (lpc >> 6);
            e.taken = hit && pht_m[i] >= 2;
            e.target = hit ? btgt_m[b] : lpc + 4;
            e.ghr = 8'(ghr_m);
        end
        if (uv) begin
            i = pidx(upc, int'(ughr));
            pht_m[i] = ut ? ((pht_m[i] + 1 > 3) ? 3 : pht_m[i] + 1) : ((pht_m[i] - 1 < 0) ? 0 : pht_m[i] - 1);
            if (ut) begin
                b = int'((upc >> 2) & 32'hF);
                bv_m[b] = 1; btag_m[b] = upc >> 6; btgt_m[b] = utgt;
            end
        end
`ifdef BP_GSHARE_EN
        if (uv && um) ghr_m = ((int'(ughr) << 1) | int'(ut)) & 255;
        else if (lv)  ghr_m = ((ghr_m << 1) | int'(e.taken)) & 255;
`endif
        @(posedge clk);
        if (lv) exp_q.push_back(e);
        #1;
        fe_req_valid = 0; upd_valid = 0; upd_mispredict = 0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(1, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        step(0, 0, 1, pc, 0, t, tgt, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        model_init();
        check("rst_ready", ready, 0);
        check("rst_pred_valid", pred_valid, 0);
        check("rst_pred_taken", pred_taken, 0);
        check("rst_pred_target", pred_target, 0);
        check("rst_pred_ghr", pred_ghr, 0);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, 256);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        wait_ready("init_len");
        lookup(32'h100);
        check("lk100_valid", pred_valid, 1);
        check("lk100_taken", pred_taken, 0);
        check("lk100_target", pred_target, 32'h104);

        do_reset();
        repeat (100) @(posedge clk);
        #1;
        check("mid_init_ready", ready, 0);
        do_reset();
        wait_ready("init_restart_len");

        update(32'h40, 1, 32'h80);
        update(32'h40, 1, 32'h80);
        lookup(32'h40);
`ifndef BP_GSHARE_EN
        check("train_taken", pred_taken, 1);
        check("train_target", pred_target, 32'h80);
`endif
        lookup(32'h440);
`ifndef BP_GSHARE_EN
        check("alias_taken", pred_taken, 0);
        check("alias_target", pred_target, 32'h444);
`endif
        repeat (5) update(32'h40, 0, 0);
        lookup(32'h40);
`ifndef BP_GSHARE_EN
        check("floor_taken", pred_taken, 0);
        check("floor_target", pred_target, 32'h80);
`endif
        update(32'h40, 1, 32'h80);
        lookup(32'h40);
`ifndef BP_GSHARE_EN
        check("floor_plus1_taken", pred_taken, 0);
`endif
        repeat (5) update(32'h40, 1, 32'h80);
        update(32'h40, 0, 0);
        lookup(32'h40);
`ifndef BP_GSHARE_EN
        check("ceiling_taken", pred_taken, 1);
`endif
        step(1, 32'h80, 1, 32'h80, 0, 1, 32'h200, 0);
        check("rbw_target", pred_target, 32'h84);
        lookup(32'h80);
`ifndef BP_GSHARE_EN
        check("after_write_target", pred_target, 32'h200);
`endif
        step(1, 32'h100, 1, 32'h200, 8'h0F, 1, 32'h300, 1);
        lookup(32'h104);
`ifdef BP_GSHARE_EN
        check("restore_ghr", pred_ghr, 32'h1F);
`else
        check("bimodal_ghr", pred_ghr, 0);
`endif

        for (int k = 0; k < 1500; k++) begin
            logic [31:0] lpc, upc;
            lpc = (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 31)) << 2);
            upc = (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 31)) << 2);
            step(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), upc, 8'($urandom),
                 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
